ahb_lite_master: RTL and testbench

AHB_LITE_MASTER -- requirements
Module: ahb_lite_master

---
 rtl/yadan_ahb_pkg.sv | 24 ++
 rtl/ahb_lite_master.sv | 231 +++++++++++++++++++++++
 tb/tb_ahb_lite_master.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/yadan_ahb_pkg.sv
// Shared AHB-Lite encodings for the yadan bus blocks.
// Holds HTRANS/HSIZE/HRESP codes, HBURST/HPROT constants and master FSM states.
package yadan_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // Only bit 0 carries meaning on AHB-Lite; used as a mask.
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HBURST_SINGLE   = 3'b000;
    localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_ERR2 = 2'b10
    } mst_state_e;

endpackage

// File: rtl/ahb_lite_master.sv
// Single-transfer AHB-Lite master with a two-deep address/data pipeline.
// Ports: HCLK/HRESET; req_* handshake in; rsp_* pulse out; AHB-Lite H* master side.
module ahb_lite_master
    import yadan_ahb_pkg::*;
(
    input  logic        HCLK,
    input  logic        HRESET,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_wdata,

    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,

    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [31:0] HWDATA,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,

    input  logic        HREADY,
    input  logic [31:0] HRDATA,
    input  logic [1:0]  HRESP
);

    mst_state_e  state_q, state_d;

    // Address-phase register; HADDR/HWRITE/HSIZE/HTRANS are its fields.
    logic        ap_valid_q, ap_valid_d;
    logic        ap_mis_q, ap_mis_d;
    logic [31:0] ap_wdata_q, ap_wdata_d;
    logic [1:0]  htrans_q, htrans_d;
    logic [31:0] haddr_q, haddr_d;
    logic        hwrite_q, hwrite_d;
    logic [2:0]  hsize_q, hsize_d;

    // Data-phase register; valid whenever state is BUSY.
    logic        dp_write_q, dp_write_d;
    logic        dp_mis_q, dp_mis_d;
    logic [31:0] hwdata_q, hwdata_d;

    // AP entry dropped by an ERROR, still owed an error response.
    logic        drop_q, drop_d;

    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic [2:0]  req_size_n;
    logic [31:0] req_wdata_rep;
    logic        req_mis;
    logic        accept;
    logic        hresp_err;
    logic        dp_busy;
    logic        fire_now;
    logic        err_first;
    logic        dp_fail;

    // Unsupported size codes behave as word.
    always_comb begin
        req_size_n = HSIZE_WORD;
        if (req_size == HSIZE_BYTE || req_size == HSIZE_HALF) begin
            req_size_n = req_size;
        end
    end

    always_comb begin
        req_wdata_rep = req_wdata;
        case (req_size_n)
            HSIZE_BYTE: req_wdata_rep = {4{req_wdata[7:0]}};
            HSIZE_HALF: req_wdata_rep = {2{req_wdata[15:0]}};
            default:    req_wdata_rep = req_wdata;
        endcase
    end

    assign req_mis = (req_size_n == HSIZE_HALF && req_addr[0])
                  || (req_size_n == HSIZE_WORD && req_addr[1:0] != 2'b00);

    assign req_ready = (!ap_valid_q || HREADY)
                    && state_q != ST_ERR2
                    && !HRESET;

    assign accept    = req_valid && req_ready;
    assign hresp_err = |(HRESP & HRESP_ERROR);
    assign dp_busy   = state_q == ST_BUSY;

    // A misaligned request with nothing older in flight is answered
    // straight away; otherwise it rides the pipeline as a non-bus entry
    // so its error response keeps request order.
    assign fire_now  = accept && req_mis && !ap_valid_q
                    && state_q == ST_IDLE;

    // First cycle of the two-cycle ERROR response.
    assign err_first = dp_busy && !dp_mis_q && hresp_err && !HREADY;

    assign dp_fail   = dp_mis_q || hresp_err;

    always_comb begin
        state_d     = state_q;
        ap_valid_d  = ap_valid_q;
        ap_mis_d    = ap_mis_q;
        ap_wdata_d  = ap_wdata_q;
        htrans_d    = htrans_q;
        haddr_d     = haddr_q;
        hwrite_d    = hwrite_q;
        hsize_d     = hsize_q;
        dp_write_d  = dp_write_q;
        dp_mis_d    = dp_mis_q;
        hwdata_d    = hwdata_q;
        drop_d      = drop_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;

        unique case (1'b1)
            state_q == ST_ERR2: begin
                if (HREADY) begin
                    state_d     = ap_valid_q ? ST_BUSY : ST_IDLE;
                    drop_d      = 1'b0;
                    rsp_valid_d = drop_q;
                    rsp_err_d   = drop_q;
                end
            end

            err_first: begin
                // Report the failed data phase now; the address
                // phase (or a request taken this edge) is dropped
                // and reported on the next response slot.
                state_d     = ST_ERR2;
                drop_d      = ap_valid_q || accept;
                ap_valid_d  = 1'b0;
                ap_mis_d    = 1'b0;
                htrans_d    = HTRANS_IDLE;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
            end

            default: begin
                if (dp_busy && HREADY) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = dp_fail;
                    if (!dp_write_q && !dp_fail) begin
                        rsp_rdata_d = HRDATA;
                    end
                end

                if (HREADY) begin
                    if (ap_valid_q) begin
                        state_d    = ST_BUSY;
                        dp_write_d = hwrite_q;
                        dp_mis_d   = ap_mis_q;
                        hwdata_d   = ap_wdata_q;
                    end
                    ap_valid_d = 1'b0;
                    ap_mis_d   = 1'b0;
                    htrans_d   = HTRANS_IDLE;
                end

                if (fire_now) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else if (accept) begin
                    ap_valid_d = 1'b1;
                    ap_mis_d   = req_mis;
                    htrans_d   = req_mis ? HTRANS_IDLE : HTRANS_NONSEQ;
                    haddr_d    = req_addr;
                    hwrite_d   = req_write;
                    hsize_d    = req_size_n;
                    ap_wdata_d = req_write ? req_wdata_rep : '0;
                end
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            ap_valid_q  <= 1'b0;
            ap_mis_q    <= 1'b0;
            ap_wdata_q  <= '0;
            htrans_q    <= HTRANS_IDLE;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            hsize_q     <= '0;
            dp_write_q  <= 1'b0;
            dp_mis_q    <= 1'b0;
            hwdata_q    <= '0;
            drop_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ap_valid_q  <= ap_valid_d;
            ap_mis_q    <= ap_mis_d;
            ap_wdata_q  <= ap_wdata_d;
            htrans_q    <= htrans_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            dp_write_q  <= dp_write_d;
            dp_mis_q    <= dp_mis_d;
            hwdata_q    <= hwdata_d;
            drop_q      <= drop_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign HTRANS    = htrans_q;
    assign HADDR     = haddr_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = hsize_q;
    assign HWDATA    = hwdata_q;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_DATA_PRIV;

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master with a small word-addressed memory slave.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_ahb_lite_master;

    logic        HCLK;
    logic        HRESET;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [2:0]  req_size;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic [1:0]  HRESP;

    int n_chk;
    int n_fail;

    ahb_lite_master dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HREADY    (HREADY),
        .HRDATA    (HRDATA),
        .HRESP     (HRESP)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Memory slave: 64 words, byte-lane writes, full-word reads.
    logic [31:0] mem [0:63];
    logic        dph_valid;
    logic        dph_write;
    logic [31:0] dph_addr;
    logic [2:0]  dph_size;
    logic [3:0]  lane_en;

    always_comb begin
        lane_en = 4'hF;
        case (dph_size)
            3'b000:  lane_en = 4'b0001 << dph_addr[1:0];
            3'b001:  lane_en = 4'b0011 << {dph_addr[1], 1'b0};
            default: lane_en = 4'hF;
        endcase
    end

    always_comb begin
        HRDATA = '0;
        if (dph_valid && !dph_write) HRDATA = mem[dph_addr[7:2]];
    end

    always @(posedge HCLK) begin
        if (HRESET) begin
            dph_valid <= 1'b0;
            dph_write <= 1'b0;
            dph_addr  <= '0;
            dph_size  <= '0;
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else if (HREADY) begin
            if (dph_valid && dph_write) begin
                for (int b = 0; b < 4; b++)
                    if (lane_en[b])
                        mem[dph_addr[7:2]][8*b +: 8] <= HWDATA[8*b +: 8];
            end
            dph_valid <= HTRANS == 2'b10;
            dph_write <= HWRITE;
            dph_addr  <= HADDR;
            dph_size  <= HSIZE;
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present one request for one edge; returns in the cycle after it.
    task automatic issue(input logic w, input logic [31:0] a,
                         input logic [2:0] s, input logic [31:0] d);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_size  = s;
        req_wdata = d;
        chk("req_ready", 32'(req_ready), 32'd1);
        @(negedge HCLK);
        req_valid = 1'b0;
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        HRESET    = 1'b1;
        HREADY    = 1'b1;
        HRESP     = 2'b00;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_size  = '0;
        req_wdata = '0;

        repeat (3) @(negedge HCLK);
        chk("rst HTRANS", 32'(HTRANS), 32'd0);
        chk("rst HADDR", HADDR, 32'd0);
        chk("rst HWRITE", 32'(HWRITE), 32'd0);
        chk("rst HSIZE", 32'(HSIZE), 32'd0);
        chk("rst HWDATA", HWDATA, 32'd0);
        chk("rst req_ready", 32'(req_ready), 32'd0);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst rsp_err", 32'(rsp_err), 32'd0);
        chk("rst rsp_rdata", rsp_rdata, 32'd0);
        chk("HBURST", 32'(HBURST), 32'd0);
        chk("HPROT", 32'(HPROT), 32'h3);
        HRESET = 1'b0;
        @(negedge HCLK);

        // Word write, zero waits: latency T+1 / T+2 / T+3.
        issue(1'b1, 32'h10, 3'b010, 32'hDEADBEEF);
        chk("t2 HTRANS", 32'(HTRANS), 32'h2);
        chk("t2 HADDR", HADDR, 32'h10);
        chk("t2 HWRITE", 32'(HWRITE), 32'd1);
        chk("t2 HSIZE", 32'(HSIZE), 32'h2);
        chk("t2 rsp early", 32'(rsp_valid), 32'd0);
        @(negedge HCLK);
        chk("t2 HWDATA", HWDATA, 32'hDEADBEEF);
        chk("t2 HTRANS idle", 32'(HTRANS), 32'd0);
        chk("t2 rsp early2", 32'(rsp_valid), 32'd0);
        @(negedge HCLK);
        chk("t2 rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t2 rsp_err", 32'(rsp_err), 32'd0);
        chk("t2 rsp_rdata", rsp_rdata, 32'd0);
        @(negedge HCLK);
        chk("t2 rsp pulse", 32'(rsp_valid), 32'd0);

        issue(1'b1, 32'h20, 3'b010, 32'h12345678);
        repeat (3) @(negedge HCLK);

        // Byte write with lane replication, then byte read-back.
        issue(1'b1, 32'h13, 3'b000, 32'h000000A5);
        chk("t3 HSIZE", 32'(HSIZE), 32'd0);
        chk("t3 HADDR", HADDR, 32'h13);
        @(negedge HCLK);
        chk("t3 HWDATA", HWDATA, 32'hA5A5A5A5);
        @(negedge HCLK);
        chk("t3 wr rsp", 32'(rsp_valid), 32'd1);
        issue(1'b0, 32'h13, 3'b000, 32'h0);
        @(negedge HCLK);
        @(negedge HCLK);
        chk("t3 rd rsp", 32'(rsp_valid), 32'd1);
        chk("t3 rd err", 32'(rsp_err), 32'd0);
        chk("t3 rd data", rsp_rdata, 32'hA5ADBEEF);
        @(negedge HCLK);

        // Back-to-back reads, two wait states in the first data phase.
        issue(1'b0, 32'h10, 3'b010, 32'h0);
        chk("t4 A HADDR", HADDR, 32'h10);
        issue(1'b0, 32'h20, 3'b010, 32'h0);
        HREADY = 1'b0;
        chk("t4 B w1 HTRANS", 32'(HTRANS), 32'h2);
        chk("t4 B w1 HADDR", HADDR, 32'h20);
        @(negedge HCLK);
        chk("t4 B w2 HTRANS", 32'(HTRANS), 32'h2);
        chk("t4 B w2 HADDR", HADDR, 32'h20);
        chk("t4 no rsp", 32'(rsp_valid), 32'd0);
        @(negedge HCLK);
        HREADY = 1'b1;
        chk("t4 B w3 HTRANS", 32'(HTRANS), 32'h2);
        chk("t4 B w3 HADDR", HADDR, 32'h20);
        chk("t4 no rsp2", 32'(rsp_valid), 32'd0);
        @(negedge HCLK);
        chk("t4 A rsp", 32'(rsp_valid), 32'd1);
        chk("t4 A data", rsp_rdata, 32'hA5ADBEEF);
        chk("t4 HTRANS idle", 32'(HTRANS), 32'd0);
        @(negedge HCLK);
        chk("t4 B rsp", 32'(rsp_valid), 32'd1);
        chk("t4 B data", rsp_rdata, 32'h12345678);
        @(negedge HCLK);
        chk("t4 done", 32'(rsp_valid), 32'd0);

        // Two-cycle ERROR on a read with a write waiting in AP.
        issue(1'b0, 32'h20, 3'b010, 32'h0);
        issue(1'b1, 32'h24, 3'b010, 32'h00000055);
        chk("t5 W HADDR", HADDR, 32'h24);
        HREADY = 1'b0;
        HRESP  = 2'b01;
        @(negedge HCLK);
        HREADY = 1'b1;
        chk("t5 HTRANS idle", 32'(HTRANS), 32'd0);
        chk("t5 err1 valid", 32'(rsp_valid), 32'd1);
        chk("t5 err1 err", 32'(rsp_err), 32'd1);
        chk("t5 err1 rdata", rsp_rdata, 32'd0);
        chk("t5 ERR2 ready", 32'(req_ready), 32'd0);
        @(negedge HCLK);
        HRESP = 2'b00;
        chk("t5 err2 valid", 32'(rsp_valid), 32'd1);
        chk("t5 err2 err", 32'(rsp_err), 32'd1);
        chk("t5 HTRANS idle2", 32'(HTRANS), 32'd0);
        @(negedge HCLK);
        chk("t5 done", 32'(rsp_valid), 32'd0);
        chk("t5 no write", mem[9], 32'd0);
        chk("t5 ready back", 32'(req_ready), 32'd1);

        // Misaligned half read; then misaligned word behind a read.
        issue(1'b0, 32'h101, 3'b001, 32'h0);
        chk("t6 no NONSEQ", 32'(HTRANS), 32'd0);
        chk("t6 mis valid", 32'(rsp_valid), 32'd1);
        chk("t6 mis err", 32'(rsp_err), 32'd1);
        @(negedge HCLK);
        chk("t6 pulse", 32'(rsp_valid), 32'd0);
        issue(1'b0, 32'h20, 3'b010, 32'h0);
        issue(1'b0, 32'h22, 3'b010, 32'h0);
        chk("t6 mis no bus", 32'(HTRANS), 32'd0);
        @(negedge HCLK);
        chk("t6 old valid", 32'(rsp_valid), 32'd1);
        chk("t6 old err", 32'(rsp_err), 32'd0);
        chk("t6 old data", rsp_rdata, 32'h12345678);
        @(negedge HCLK);
        chk("t6 mis2 valid", 32'(rsp_valid), 32'd1);
        chk("t6 mis2 err", 32'(rsp_err), 32'd1);
        @(negedge HCLK);

        // Reset during a data phase discards the transfer.
        issue(1'b0, 32'h20, 3'b010, 32'h0);
        @(negedge HCLK);
        HRESET = 1'b1;
        @(negedge HCLK);
        chk("t7 HTRANS", 32'(HTRANS), 32'd0);
        chk("t7 req_ready", 32'(req_ready), 32'd0);
        chk("t7 no rsp", 32'(rsp_valid), 32'd0);
        HRESET = 1'b0;
        @(negedge HCLK);
        chk("t7 no rsp2", 32'(rsp_valid), 32'd0);
        chk("t7 ready", 32'(req_ready), 32'd1);
        @(negedge HCLK);
        chk("t7 no rsp3", 32'(rsp_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
